// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants for the regfile_ng slice: default geometry
//                and the INIT/RUN state encoding used by the sweep sequencer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_def_width = 16;
    localparam int c_def_depth = 16;
    localparam int c_def_nrd   = 2;

    // One-bit state encoding: INIT sweeps zeros through the array, RUN is normal use.
    localparam int         c_state_w  = 1;
    localparam logic [0:0] c_st_init  = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_init_seq
//  Description : INIT/RUN controller with the clearing sweep counter. In INIT
//                it presents one entry address per cycle for zeroing; after
//                entry DEPTH-1 it moves to RUN. A clr request in RUN restarts
//                the sweep; clr while sweeping has no effect.
//  Ports       : clk      - clock, rising edge
//                reset    - synchronous active-high reset (restarts sweep)
//                clr      - one-cycle re-zero request (honoured in RUN only)
//                ready    - high while in RUN
//                clr_en   - high while sweeping (clear write enable)
//                clr_addr - entry being cleared this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = c_def_depth,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          ready,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    logic [c_state_w-1:0] r_state;
    logic [AW-1:0]        r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_init;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_init: begin
                    // Counter wraps to zero on the last entry, so RUN starts with cnt=0.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= c_st_run;
                    end
                end
                default: begin
                    if (clr) begin
                        r_state <= c_st_init;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign ready    = (r_state == c_st_run);
    assign clr_en   = (r_state == c_st_init);
    assign clr_addr = r_cnt;

endmodule : regfile_init_seq
`default_nettype wire

// File: rtl/regfile_ng.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_ng
//  Description : Multi-read-port register file with one write port, optional
//                hard-wired zero register, optional write-to-read forwarding
//                and a sweep-based clear after reset or clr.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous active-high reset
//                clr   - one-cycle request to re-zero all entries
//                ready - array initialised, writes accepted
//                we/wa/wd - write enable, address, data
//                ra    - NRD packed read addresses, port k at [k*AW +: AW]
//                rd    - NRD packed read data, port k at [k*WIDTH +: WIDTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_ng
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = c_def_width,
    parameter  int DEPTH    = c_def_depth,
    parameter  int NRD      = c_def_nrd,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd
);

    logic          w_ready;
    logic          w_clr_en;
    logic [AW-1:0] w_clr_addr;
    logic          w_writable;
    logic          w_fwd_en;
    logic          w_wr_en;

    // Storage carries no reset; its contents become defined only via the sweep.
    logic [WIDTH-1:0] r_mem [DEPTH];

    regfile_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .ready    (w_ready),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr)
    );

    assign ready      = w_ready;
    assign w_writable = (ZERO_REG == 0) || (wa != '0);
    // Forwarding follows the user write request; the commit additionally drops
    // writes that coincide with a clr request or a reset.
    assign w_fwd_en   = w_ready && we && w_writable;
    assign w_wr_en    = w_fwd_en && !clr && !reset;

    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
        end
    end

    always_comb begin
        rd = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!w_ready) begin
                rd[k*WIDTH +: WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0)) begin
                rd[k*WIDTH +: WIDTH] = '0;
            end else if ((BYPASS != 0) && w_fwd_en && (ra[k*AW +: AW] == wa)) begin
                rd[k*WIDTH +: WIDTH] = wd;
            end else begin
                rd[k*WIDTH +: WIDTH] = r_mem[ra[k*AW +: AW]];
            end
        end
    end

endmodule : regfile_ng
`default_nettype wire

// File: tb/tb_regfile_ng.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_ng
//  Description : Self-checking bench for regfile_ng (NRD=4, BYPASS=1,
//                ZERO_REG=1, 16x16). Table-driven read/write vectors plus
//                hand-written sweep, clr and reset-restart sequences.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ng;

    localparam int c_w   = 16;
    localparam int c_d   = 16;
    localparam int c_nrd = 4;
    localparam int c_aw  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clr;
    logic                 ready;
    logic                 we;
    logic [c_aw-1:0]      wa;
    logic [c_w-1:0]       wd;
    logic [c_nrd*c_aw-1:0] ra;
    logic [c_nrd*c_w-1:0]  rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] ra;   // port k at [k*4 +: 4]
        logic [63:0] exp;  // port k at [k*16 +: 16]
    } vec_t;

    vec_t tbl [12];

    regfile_ng #(
        .WIDTH    (c_w),
        .DEPTH    (c_d),
        .NRD      (c_nrd),
        .BYPASS   (1),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .ready (ready),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra),
        .rd    (rd)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [15:0] d,
                                input logic [3:0] r0, input logic [3:0] r1,
                                input logic [3:0] r2, input logic [3:0] r3,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.we  = w;
        v.wa  = a;
        v.wd  = d;
        v.ra  = {r3, r2, r1, r0};
        v.exp = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with ready low (sampled after each edge), bounded.
    // pulse_at > 0 raises clr for one cycle at that count to prove it is ignored.
    task automatic count_init(input int pulse_at, output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            cycles++;
            if (cycles == pulse_at) clr = 1'b1;
            tick();
            clr = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < c_d; a += c_nrd) begin
            ra = {4'(a + 3), 4'(a + 2), 4'(a + 1), 4'(a)};
            #1;
            for (int k = 0; k < c_nrd; k++) chk(name, 32'(rd[k*c_w +: c_w]), 32'h0);
        end
    endtask

    initial begin
        int cyc;

        reset = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;

        // Reset state and initial sweep timing.
        tick();
        reset = 1'b0;
        chk("ready_after_reset", 32'(ready), 32'h0);
        ra = {4'd3, 4'd2, 4'd1, 4'd9};
        #1;
        chk("rd_zero_in_init", 32'(rd), 32'h0);
        count_init(0, cyc);
        chk("init_sweep_cycles", 32'(cyc), 32'd16);
        chk("ready_after_sweep", 32'(ready), 32'h1);
        check_all_zero("rd_zero_after_sweep");

        // Directed vectors: rd checked combinationally before the edge.
        tbl[0]  = mk(1, 5,  16'hBEEF, 5, 0, 1, 2,   16'hBEEF, 16'h0, 16'h0, 16'h0);
        tbl[1]  = mk(0, 0,  16'h0,    5, 5, 5, 5,   16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        tbl[2]  = mk(1, 0,  16'h1234, 0, 0, 5, 3,   16'h0, 16'h0, 16'hBEEF, 16'h0);
        tbl[3]  = mk(0, 0,  16'h0,    0, 0, 5, 5,   16'h0, 16'h0, 16'hBEEF, 16'hBEEF);
        tbl[4]  = mk(1, 2,  16'h0222, 2, 7, 9, 15,  16'h0222, 16'h0, 16'h0, 16'h0);
        tbl[5]  = mk(1, 7,  16'h0777, 2, 7, 9, 15,  16'h0222, 16'h0777, 16'h0, 16'h0);
        tbl[6]  = mk(1, 9,  16'h0999, 2, 7, 9, 15,  16'h0222, 16'h0777, 16'h0999, 16'h0);
        tbl[7]  = mk(1, 15, 16'h0F0F, 2, 7, 9, 15,  16'h0222, 16'h0777, 16'h0999, 16'h0F0F);
        tbl[8]  = mk(0, 0,  16'h0,    2, 7, 9, 15,  16'h0222, 16'h0777, 16'h0999, 16'h0F0F);
        tbl[9]  = mk(0, 0,  16'h0,    7, 7, 7, 7,   16'h0777, 16'h0777, 16'h0777, 16'h0777);
        tbl[10] = mk(1, 7,  16'hABCD, 7, 7, 2, 5,   16'hABCD, 16'hABCD, 16'h0222, 16'hBEEF);
        tbl[11] = mk(0, 0,  16'h0,    7, 15, 1, 5,  16'hABCD, 16'h0F0F, 16'h0, 16'hBEEF);

        for (int i = 0; i < 12; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; ra = tbl[i].ra;
            #1;
            for (int k = 0; k < c_nrd; k++) begin
                chk($sformatf("vec%0d_port%0d", i, k), 32'(rd[k*c_w +: c_w]),
                    32'(tbl[i].exp[k*c_w +: c_w]));
            end
            tick();
        end
        we = 1'b0;

        // Fill 1..15, then clr with a simultaneous write to entry 3.
        for (int a = 1; a < c_d; a++) begin
            we = 1'b1; wa = 4'(a); wd = 16'h1000 + 16'(a);
            tick();
        end
        we = 1'b0;
        ra = {4'd15, 4'd14, 4'd3, 4'd1};
        #1;
        chk("fill_entry1", 32'(rd[0 +: 16]), 32'h1001);
        chk("fill_entry3", 32'(rd[16 +: 16]), 32'h1003);
        chk("fill_entry15", 32'(rd[48 +: 16]), 32'h100F);

        clr = 1'b1; we = 1'b1; wa = 4'd3; wd = 16'h5555;
        tick();
        clr = 1'b0; we = 1'b0;
        chk("ready_after_clr", 32'(ready), 32'h0);
        ra = {4'd15, 4'd14, 4'd3, 4'd1};
        #1;
        chk("rd_zero_in_clr_sweep", 32'(rd), 32'h0);
        // Writes during the sweep must be ignored.
        we = 1'b1; wa = 4'd15; wd = 16'h7777;
        tick();
        we = 1'b0;
        // A second clr in the middle of the sweep must not restart it.
        count_init(5, cyc);
        chk("clr_sweep_cycles", 32'(cyc + 1), 32'd16);
        chk("ready_after_clr_sweep", 32'(ready), 32'h1);
        ra = {4'd15, 4'd14, 4'd3, 4'd3};
        #1;
        chk("entry3_after_clr", 32'(rd[0 +: 16]), 32'h0);
        chk("entry15_after_clr", 32'(rd[48 +: 16]), 32'h0);
        check_all_zero("rd_zero_after_clr");

        // Reset mid-sweep restarts the sweep from entry 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("ready_low_mid_sweep", 32'(ready), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_init(0, cyc);
        chk("reset_restart_cycles", 32'(cyc), 32'd16);
        chk("ready_after_restart", 32'(ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_ng
`default_nettype wire
